// File: rtl/combat_resolver.sv
// Resolves landed basic attacks between two players, tracks health and hit-stun,
// and sequences the round through FIGHT, KO and DONE.
module combat_resolver #(
    parameter int unsigned HP_W     = 3,
    parameter int unsigned MAX_HP   = 5,
    parameter int unsigned STUN_CYC = 8,
    parameter int unsigned KO_CYC   = 60
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic [3:0]      p1_state,
    input  logic [3:0]      p2_state,
    input  logic [9:0]      p1_hit_x1,
    input  logic [9:0]      p1_hit_x2,
    input  logic [9:0]      p1_hit_y1,
    input  logic [9:0]      p1_hit_y2,
    input  logic [9:0]      p2_hit_x1,
    input  logic [9:0]      p2_hit_x2,
    input  logic [9:0]      p2_hit_y1,
    input  logic [9:0]      p2_hit_y2,
    input  logic [9:0]      p1_hurt_x1,
    input  logic [9:0]      p1_hurt_x2,
    input  logic [9:0]      p1_hurt_y1,
    input  logic [9:0]      p1_hurt_y2,
    input  logic [9:0]      p2_hurt_x1,
    input  logic [9:0]      p2_hurt_x2,
    input  logic [9:0]      p2_hurt_y1,
    input  logic [9:0]      p2_hurt_y2,
    output logic [HP_W-1:0] p1_hp,
    output logic [HP_W-1:0] p2_hp,
    output logic            p1_hit,
    output logic            p2_hit,
    output logic            p1_stun,
    output logic            p2_stun,
    output logic            freeze,
    output logic [1:0]      phase,
    output logic [1:0]      winner
);

    localparam int unsigned STUN_W = $clog2(STUN_CYC + 1);
    localparam int unsigned KO_W   = $clog2(KO_CYC + 1);

    typedef enum logic [1:0] {
        PH_FIGHT = 2'd0,
        PH_KO    = 2'd1,
        PH_DONE  = 2'd2
    } phase_e;

    // Inclusive overlap of two boxes whose corners may arrive in either order.
    function automatic logic boxes_overlap(
        input logic [9:0] ax1, input logic [9:0] ax2, input logic [9:0] ay1, input logic [9:0] ay2,
        input logic [9:0] bx1, input logic [9:0] bx2, input logic [9:0] by1, input logic [9:0] by2
    );
        logic [9:0] alx, ahx, aly, ahy, blx, bhx, bly, bhy;
        alx = (ax1 < ax2) ? ax1 : ax2;
        ahx = (ax1 < ax2) ? ax2 : ax1;
        aly = (ay1 < ay2) ? ay1 : ay2;
        ahy = (ay1 < ay2) ? ay2 : ay1;
        blx = (bx1 < bx2) ? bx1 : bx2;
        bhx = (bx1 < bx2) ? bx2 : bx1;
        bly = (by1 < by2) ? by1 : by2;
        bhy = (by1 < by2) ? by2 : by1;
        return (alx <= bhx) && (blx <= ahx) && (aly <= bhy) && (bly <= ahy);
    endfunction

    function automatic logic in_swing(input logic [3:0] s);
        return (s == 4'd3) || (s == 4'd4) || (s == 4'd5);
    endfunction

    phase_e            phase_q, phase_d;
    logic [HP_W-1:0]   p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
    logic              p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
    logic [STUN_W-1:0] p1_stun_cnt_q, p1_stun_cnt_d, p2_stun_cnt_q, p2_stun_cnt_d;
    logic              p1_stun_q, p1_stun_d, p2_stun_q, p2_stun_d;
    logic              p1_done_q, p1_done_d, p2_done_q, p2_done_d;
    logic [1:0]        winner_q, winner_d;
    logic [KO_W-1:0]   ko_cnt_q, ko_cnt_d;
    logic              freeze_q, freeze_d;
    logic              p1_lands, p2_lands;

    assign p1_lands = (phase_q == PH_FIGHT) && (p1_state == 4'd4) && !p1_done_q &&
                      boxes_overlap(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
                                    p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
    assign p2_lands = (phase_q == PH_FIGHT) && (p2_state == 4'd4) && !p2_done_q &&
                      boxes_overlap(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
                                    p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);

    always_comb begin
        phase_d       = phase_q;
        p1_hp_d       = p1_hp_q;
        p2_hp_d       = p2_hp_q;
        p1_hit_d      = 1'b0;
        p2_hit_d      = 1'b0;
        p1_stun_cnt_d = (p1_stun_cnt_q != '0) ? p1_stun_cnt_q - STUN_W'(1) : '0;
        p2_stun_cnt_d = (p2_stun_cnt_q != '0) ? p2_stun_cnt_q - STUN_W'(1) : '0;
        p1_done_d     = p1_done_q && in_swing(p1_state);
        p2_done_d     = p2_done_q && in_swing(p2_state);
        winner_d      = winner_q;
        ko_cnt_d      = ko_cnt_q;

        case (phase_q)
            PH_FIGHT: begin
                if (p1_lands) begin
                    p2_hit_d      = 1'b1;
                    p2_hp_d       = (p2_hp_q != '0) ? p2_hp_q - HP_W'(1) : '0;
                    p2_stun_cnt_d = STUN_W'(STUN_CYC);
                    p1_done_d     = 1'b1;
                end
                if (p2_lands) begin
                    p1_hit_d      = 1'b1;
                    p1_hp_d       = (p1_hp_q != '0) ? p1_hp_q - HP_W'(1) : '0;
                    p1_stun_cnt_d = STUN_W'(STUN_CYC);
                    p2_done_d     = 1'b1;
                end
                if ((p1_hp_d == '0) || (p2_hp_d == '0)) begin
                    phase_d  = PH_KO;
                    ko_cnt_d = '0;
                    if ((p1_hp_d == '0) && (p2_hp_d == '0)) winner_d = 2'd3;
                    else if (p2_hp_d == '0)                  winner_d = 2'd1;
                    else                                     winner_d = 2'd2;
                end
            end
            PH_KO: begin
                if (ko_cnt_q == KO_W'(KO_CYC - 1)) phase_d  = PH_DONE;
                else                               ko_cnt_d = ko_cnt_q + KO_W'(1);
            end
            PH_DONE: begin
                if (restart) begin
                    phase_d       = PH_FIGHT;
                    p1_hp_d       = HP_W'(MAX_HP);
                    p2_hp_d       = HP_W'(MAX_HP);
                    winner_d      = 2'd0;
                    p1_stun_cnt_d = '0;
                    p2_stun_cnt_d = '0;
                    p1_done_d     = 1'b0;
                    p2_done_d     = 1'b0;
                end
            end
            default: phase_d = PH_FIGHT;
        endcase

        freeze_d  = (phase_d != PH_FIGHT);
        p1_stun_d = (p1_stun_cnt_d != '0);
        p2_stun_d = (p2_stun_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= PH_FIGHT;
            p1_hp_q       <= HP_W'(MAX_HP);
            p2_hp_q       <= HP_W'(MAX_HP);
            p1_hit_q      <= 1'b0;
            p2_hit_q      <= 1'b0;
            p1_stun_cnt_q <= '0;
            p2_stun_cnt_q <= '0;
            p1_stun_q     <= 1'b0;
            p2_stun_q     <= 1'b0;
            p1_done_q     <= 1'b0;
            p2_done_q     <= 1'b0;
            winner_q      <= 2'd0;
            ko_cnt_q      <= '0;
            freeze_q      <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            p1_hp_q       <= p1_hp_d;
            p2_hp_q       <= p2_hp_d;
            p1_hit_q      <= p1_hit_d;
            p2_hit_q      <= p2_hit_d;
            p1_stun_cnt_q <= p1_stun_cnt_d;
            p2_stun_cnt_q <= p2_stun_cnt_d;
            p1_stun_q     <= p1_stun_d;
            p2_stun_q     <= p2_stun_d;
            p1_done_q     <= p1_done_d;
            p2_done_q     <= p2_done_d;
            winner_q      <= winner_d;
            ko_cnt_q      <= ko_cnt_d;
            freeze_q      <= freeze_d;
        end
    end

    assign p1_hp   = p1_hp_q;
    assign p2_hp   = p2_hp_q;
    assign p1_hit  = p1_hit_q;
    assign p2_hit  = p2_hit_q;
    assign p1_stun = p1_stun_q;
    assign p2_stun = p2_stun_q;
    assign freeze  = freeze_q;
    assign phase   = phase_q;
    assign winner  = winner_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Directed and randomized checks of combat_resolver against a cycle-level
// reference model of the round rules.
module tb_combat_resolver;

    localparam int MAX   = 5;
    localparam int STUN  = 8;
    localparam int KO    = 60;

    logic       clk = 1'b0;
    logic       rst, restart;
    logic [3:0] p1_state, p2_state;
    logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
    logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
    logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
    logic [2:0] p1_hp, p2_hp;
    logic       p1_hit, p2_hit, p1_stun, p2_stun, freeze;
    logic [1:0] phase, winner;

    combat_resolver dut (
        .clk(clk), .rst(rst), .restart(restart),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2), .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
        .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2), .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2), .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2), .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
        .p1_hp(p1_hp), .p2_hp(p2_hp), .p1_hit(p1_hit), .p2_hit(p2_hit),
        .p1_stun(p1_stun), .p2_stun(p2_stun), .freeze(freeze), .phase(phase), .winner(winner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_p1hit, n_p2hit, n_p2stun;

    // Reference model state: plain integers describing the round.
    int m_phase, m_hp1, m_hp2, m_hit1, m_hit2, m_stun1, m_stun2, m_done1, m_done2, m_win, m_ko;

    int seq_a [6] = '{3, 4, 5, 0, 3, 4};
    int seq_b [4] = '{4, 4, 3, 4};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Two closed intervals intersect when the smaller top is not below the larger bottom.
    function automatic bit span_meet(int a1, int a2, int b1, int b2);
        int top, bot;
        top = (a1 > a2 ? a1 : a2) < (b1 > b2 ? b1 : b2) ? (a1 > a2 ? a1 : a2) : (b1 > b2 ? b1 : b2);
        bot = (a1 < a2 ? a1 : a2) > (b1 < b2 ? b1 : b2) ? (a1 < a2 ? a1 : a2) : (b1 < b2 ? b1 : b2);
        return top - bot >= 0;
    endfunction

    task automatic model_step();
        bit on2, on1;
        if (rst) begin
            m_phase = 0; m_hp1 = MAX; m_hp2 = MAX; m_hit1 = 0; m_hit2 = 0;
            m_stun1 = 0; m_stun2 = 0; m_done1 = 0; m_done2 = 0; m_win = 0; m_ko = 0;
            return;
        end
        on2 = (m_phase == 0) && (p1_state == 4) && !m_done1 &&
              span_meet(p1_hit_x1, p1_hit_x2, p2_hurt_x1, p2_hurt_x2) &&
              span_meet(p1_hit_y1, p1_hit_y2, p2_hurt_y1, p2_hurt_y2);
        on1 = (m_phase == 0) && (p2_state == 4) && !m_done2 &&
              span_meet(p2_hit_x1, p2_hit_x2, p1_hurt_x1, p1_hurt_x2) &&
              span_meet(p2_hit_y1, p2_hit_y2, p1_hurt_y1, p1_hurt_y2);
        m_hit1  = on1;
        m_hit2  = on2;
        m_stun1 = on1 ? STUN : (m_stun1 > 0 ? m_stun1 - 1 : 0);
        m_stun2 = on2 ? STUN : (m_stun2 > 0 ? m_stun2 - 1 : 0);
        m_done1 = on2 ? 1 : ((p1_state inside {3, 4, 5}) ? m_done1 : 0);
        m_done2 = on1 ? 1 : ((p2_state inside {3, 4, 5}) ? m_done2 : 0);
        if (on1 && m_hp1 > 0) m_hp1--;
        if (on2 && m_hp2 > 0) m_hp2--;
        case (m_phase)
            0: if (m_hp1 == 0 || m_hp2 == 0) begin
                   m_phase = 1;
                   m_ko    = 0;
                   m_win   = (m_hp1 == 0 && m_hp2 == 0) ? 3 : (m_hp2 == 0 ? 1 : 2);
               end
            1: begin
                   m_ko++;
                   if (m_ko == KO) m_phase = 2;
               end
            default: if (restart) begin
                   m_phase = 0; m_hp1 = MAX; m_hp2 = MAX; m_win = 0;
                   m_stun1 = 0; m_stun2 = 0; m_done1 = 0; m_done2 = 0;
               end
        endcase
    endtask

    task automatic compare_all();
        check_eq("p1_hp", int'(p1_hp), m_hp1);
        check_eq("p2_hp", int'(p2_hp), m_hp2);
        check_eq("p1_hit", int'(p1_hit), m_hit1);
        check_eq("p2_hit", int'(p2_hit), m_hit2);
        check_eq("p1_stun", int'(p1_stun), int'(m_stun1 != 0));
        check_eq("p2_stun", int'(p2_stun), int'(m_stun2 != 0));
        check_eq("phase", int'(phase), m_phase);
        check_eq("freeze", int'(freeze), int'(m_phase != 0));
        check_eq("winner", int'(winner), m_win);
        if (p1_hit)  n_p1hit++;
        if (p2_hit)  n_p2hit++;
        if (p2_stun) n_p2stun++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        n_p1hit = 0; n_p2hit = 0; n_p2stun = 0;
    endtask

    task automatic geom_s1();
        p1_hit_x1  = 10'd247; p1_hit_x2  = 10'd323; p1_hit_y1  = 10'd194; p1_hit_y2  = 10'd227;
        p2_hurt_x1 = 10'd306; p2_hurt_x2 = 10'd257; p2_hurt_y1 = 10'd170; p2_hurt_y2 = 10'd320;
    endtask

    task automatic rand_box(output logic [9:0] x1, output logic [9:0] x2,
                            output logic [9:0] y1, output logic [9:0] y2);
        int lx, ly, wx, wy;
        lx = $urandom_range(200, 300); wx = $urandom_range(0, 80);
        ly = $urandom_range(200, 300); wy = $urandom_range(0, 80);
        if ($urandom_range(0, 1) == 1) begin x1 = 10'(lx); x2 = 10'(lx + wx); end
        else                           begin x1 = 10'(lx + wx); x2 = 10'(lx); end
        if ($urandom_range(0, 1) == 1) begin y1 = 10'(ly); y2 = 10'(ly + wy); end
        else                           begin y1 = 10'(ly + wy); y2 = 10'(ly); end
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; p1_state = 4'd0; p2_state = 4'd0;
        p1_hit_x1 = '0; p1_hit_x2 = '0; p1_hit_y1 = '0; p1_hit_y2 = '0;
        p2_hit_x1 = '0; p2_hit_x2 = '0; p2_hit_y1 = '0; p2_hit_y2 = '0;
        p1_hurt_x1 = '0; p1_hurt_x2 = '0; p1_hurt_y1 = '0; p1_hurt_y2 = '0;
        p2_hurt_x1 = 10'd900; p2_hurt_x2 = 10'd950; p2_hurt_y1 = 10'd900; p2_hurt_y2 = 10'd950;

        // Reset values.
        do_reset();
        check_eq("rst_hp", int'(p2_hp), 5);
        check_eq("rst_phase", int'(phase), 0);

        // Single swing held three cycles in the active state.
        geom_s1();
        p1_state = 4'd4;
        tick();
        check_eq("s1_first_pulse", int'(p2_hit), 1);
        tick(); tick();
        p1_state = 4'd0;
        repeat (10) tick();
        check_eq("s1_pulses", n_p2hit, 1);
        check_eq("s1_stun_cycles", n_p2stun, 8);
        check_eq("s1_hp", int'(p2_hp), 4);

        // Inclusive x edge: one past misses, exactly touching hits.
        do_reset();
        geom_s1();
        p2_hurt_x1 = 10'd400; p2_hurt_x2 = 10'd324;
        p1_state = 4'd4; tick(); p1_state = 4'd0; tick();
        check_eq("edge_miss_hp", int'(p2_hp), 5);
        p2_hurt_x2 = 10'd323;
        p1_state = 4'd4; tick();
        check_eq("edge_hit_pulse", int'(p2_hit), 1);
        p1_state = 4'd0; tick();
        check_eq("edge_hit_hp", int'(p2_hp), 4);

        // Hit latch re-arms only through a non-attack state.
        do_reset();
        geom_s1();
        foreach (seq_a[i]) begin p1_state = 4'(seq_a[i]); tick(); end
        p1_state = 4'd0; tick();
        check_eq("rearm_hp", int'(p2_hp), 3);
        do_reset();
        foreach (seq_b[i]) begin p1_state = 4'(seq_b[i]); tick(); end
        p1_state = 4'd0; tick();
        check_eq("no_rearm_hp", int'(p2_hp), 4);
        check_eq("no_rearm_pulses", n_p2hit, 1);

        // Trades down to a double KO.
        do_reset();
        geom_s1();
        p2_hit_x1  = 10'd300; p2_hit_x2  = 10'd200; p2_hit_y1  = 10'd250; p2_hit_y2  = 10'd200;
        p1_hurt_x1 = 10'd150; p1_hurt_x2 = 10'd260; p1_hurt_y1 = 10'd100; p1_hurt_y2 = 10'd300;
        repeat (4) begin
            p1_state = 4'd4; p2_state = 4'd4; tick();
            check_eq("trade_p1_pulse", int'(p1_hit), 1);
            check_eq("trade_p2_pulse", int'(p2_hit), 1);
            p1_state = 4'd0; p2_state = 4'd0; tick();
        end
        check_eq("trade_hp1", int'(p1_hp), 1);
        check_eq("trade_hp2", int'(p2_hp), 1);
        p1_state = 4'd4; p2_state = 4'd4; tick();
        check_eq("draw_phase", int'(phase), 1);
        check_eq("draw_winner", int'(winner), 3);
        p1_state = 4'd0; p2_state = 4'd0;

        // P1 wins, KO ignores attacks, DONE waits for restart.
        do_reset();
        repeat (4) begin p1_state = 4'd4; tick(); p1_state = 4'd0; tick(); end
        p1_state = 4'd4; tick();
        check_eq("ko_phase", int'(phase), 1);
        check_eq("ko_freeze", int'(freeze), 1);
        check_eq("ko_winner", int'(winner), 1);
        n_p1hit = 0; n_p2hit = 0;
        for (int i = 0; i < KO - 1; i++) begin
            p1_state = (i % 2 == 0) ? 4'd0 : 4'd4;
            p2_state = (i % 2 == 0) ? 4'd4 : 4'd0;
            tick();
        end
        check_eq("ko_hold_phase", int'(phase), 1);
        tick();
        check_eq("done_phase", int'(phase), 2);
        check_eq("ko_no_pulses", n_p1hit + n_p2hit, 0);
        p1_state = 4'd0; p2_state = 4'd0;
        tick();
        check_eq("done_hold", int'(phase), 2);
        restart = 1'b1; tick(); restart = 1'b0;
        check_eq("restart_phase", int'(phase), 0);
        check_eq("restart_hp", int'(p2_hp), 5);
        check_eq("restart_winner", int'(winner), 0);
        check_eq("restart_freeze", int'(freeze), 0);

        // Reset mid-KO, then restart during FIGHT does nothing.
        repeat (5) begin p1_state = 4'd4; tick(); p1_state = 4'd0; tick(); end
        check_eq("ko2_phase", int'(phase), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("ko_rst_phase", int'(phase), 0);
        check_eq("ko_rst_hp", int'(p2_hp), 5);
        check_eq("ko_rst_winner", int'(winner), 0);
        p1_state = 4'd4; tick(); p1_state = 4'd0; tick();
        restart = 1'b1; tick(); restart = 1'b0;
        check_eq("fight_restart_hp", int'(p2_hp), 4);

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            int s1, s2;
            s1 = $urandom_range(0, 9); s2 = $urandom_range(0, 9);
            p1_state = 4'(s1 > 5 ? 4 : s1);
            p2_state = 4'(s2 > 5 ? 4 : s2);
            if ($urandom_range(0, 3) == 0) begin
                rand_box(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2);
                rand_box(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2);
                rand_box(p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);
                rand_box(p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
            end
            restart = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; restart = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
